sram_arb_sync: RTL and testbench

SRAM_ARB_SYNC -- requirements
Module: sram_arb_sync

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_arb_sel_sync.sv | 24 ++
 rtl/sram_arb_sync.sv | 162 ++++++++++++++++
 tb/tb_sram_arb_sync.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the two-port SRAM arbiter/controller.
package sram_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 20;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int RD_CYCLES_DEF  = 2;
    localparam int WR_CYCLES_DEF  = 2;
    localparam int CNT_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_WHOLD
    } state_t;

endpackage

// File: rtl/sram_arb_sel_sync.sv
// Two-flop synchronizer for the grant select; resets to the sopc port (0).
module sram_arb_sel_sync (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sram_arb_sync.sv
// Two-port asynchronous-SRAM controller with select-based grant; all strobes registered.
// SRAM_ARB_SEL_SYNC_EN: route sel through a 2-flop synchronizer (+2 cycles grant latency).
module sram_arb_sync
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_CYCLES  = RD_CYCLES_DEF,
    parameter int WR_CYCLES  = WR_CYCLES_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sel,
    output logic [ADDR_WIDTH-1:0] sram_address,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [1:0]            sram_be_n,
    input  logic [ADDR_WIDTH-1:0] sopc_address,
    input  logic [1:0]            sopc_byteenable,
    input  logic                  sopc_read,
    input  logic                  sopc_write,
    input  logic [DATA_WIDTH-1:0] sopc_writedata,
    input  logic [ADDR_WIDTH-1:0] tr_address,
    input  logic [1:0]            tr_byteenable,
    input  logic                  tr_read,
    input  logic                  tr_write,
    input  logic [DATA_WIDTH-1:0] tr_writedata,
    output logic [DATA_WIDTH-1:0] sopc_readdata,
    output logic                  sopc_readdataready,
    output logic                  sopc_waitrequest
);

    localparam int LANE = DATA_WIDTH / 2;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    logic sel_eff;
`ifdef SRAM_ARB_SEL_SYNC_EN
    sram_arb_sel_sync u_sel_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (sel),
        .q_o   (sel_eff)
    );
`else
    assign sel_eff = sel;
`endif

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  gnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            be_n_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  ce_n_q, oe_n_q, we_n_q, drive_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rdv_q;

    logic                  gnt_d;
    logic                  g_read, g_write;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [1:0]            g_be;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Grant follows sel only while idle so a transfer never switches owner mid-flight.
    assign gnt_d = (state_q == ST_IDLE) ? sel_eff : gnt_q;

    always_comb begin
        g_read  = gnt_d ? tr_read        : sopc_read;
        g_write = gnt_d ? tr_write       : sopc_write;
        g_addr  = gnt_d ? tr_address     : sopc_address;
        g_be    = gnt_d ? tr_byteenable  : sopc_byteenable;
        g_wdata = gnt_d ? tr_writedata   : sopc_writedata;
    end

    always_comb begin
        rdata_d = '0;
        if (!be_n_q[0]) rdata_d[LANE-1:0]          = sram_data[LANE-1:0];
        if (!be_n_q[1]) rdata_d[DATA_WIDTH-1:LANE] = sram_data[DATA_WIDTH-1:LANE];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            be_n_q  <= 2'b11;
            wdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
            rdata_q <= '0;
            rdv_q   <= 1'b0;
        end else begin
            gnt_q <= gnt_d;
            rdv_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (g_read) begin
                        addr_q  <= g_addr;
                        be_n_q  <= ~g_be;
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= 1'b0;
                        state_q <= ST_READ;
                    end else if (g_write) begin
                        addr_q  <= g_addr;
                        be_n_q  <= ~g_be;
                        wdata_q <= g_wdata;
                        ce_n_q  <= 1'b0;
                        we_n_q  <= 1'b0;
                        drive_q <= 1'b1;
                        state_q <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (cnt_q == RD_LAST) begin
                        rdata_q <= rdata_d;
                        rdv_q   <= 1'b1;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        be_n_q  <= 2'b11;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == WR_LAST) begin
                        we_n_q  <= 1'b1;
                        state_q <= ST_WHOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WHOLD: begin
                    ce_n_q  <= 1'b1;
                    be_n_q  <= 2'b11;
                    drive_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sram_data          = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign sram_address       = addr_q;
    assign sram_ce_n          = ce_n_q;
    assign sram_oe_n          = oe_n_q;
    assign sram_we_n          = we_n_q;
    assign sram_be_n          = be_n_q;
    assign sopc_readdata      = rdata_q;
    assign sopc_readdataready = rdv_q;
    assign sopc_waitrequest   = reset | ((g_read | g_write) & (state_q != ST_IDLE));

endmodule

// File: tb/tb_sram_arb_sync.sv
// Bench for sram_arb_sync: behavioural SRAM device, cycle-schedule reference model, directed tests.
`timescale 1ns/1ps
module tb_sram_arb_sync;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int RD = 2;
    localparam int WR = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          sel;
    wire  [DW-1:0] sram_data;
    logic [AW-1:0] sram_address;
    logic          sram_ce_n, sram_oe_n, sram_we_n;
    logic [1:0]    sram_be_n;
    logic [AW-1:0] sopc_address, tr_address;
    logic [1:0]    sopc_byteenable, tr_byteenable;
    logic          sopc_read, sopc_write, tr_read, tr_write;
    logic [DW-1:0] sopc_writedata, tr_writedata;
    logic [DW-1:0] sopc_readdata;
    logic          sopc_readdataready, sopc_waitrequest;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] dev_mem [64];
    logic [DW-1:0] ref_mem [64];

    sram_arb_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
        .clock(clock), .reset(reset), .sel(sel),
        .sram_address(sram_address), .sram_data(sram_data),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
        .sopc_address(sopc_address), .sopc_byteenable(sopc_byteenable), .sopc_read(sopc_read),
        .sopc_write(sopc_write), .sopc_writedata(sopc_writedata),
        .tr_address(tr_address), .tr_byteenable(tr_byteenable), .tr_read(tr_read),
        .tr_write(tr_write), .tr_writedata(tr_writedata),
        .sopc_readdata(sopc_readdata), .sopc_readdataready(sopc_readdataready),
        .sopc_waitrequest(sopc_waitrequest)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Asynchronous SRAM device: drives the bus when selected for read, writes on edges with we_n low.
    assign sram_data = (!sram_ce_n && !sram_oe_n) ? dev_mem[sram_address[5:0]] : {DW{1'bz}};
    always @(posedge clock) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_be_n[0]) dev_mem[sram_address[5:0]][7:0]  = sram_data[7:0];
            if (!sram_be_n[1]) dev_mem[sram_address[5:0]][15:8] = sram_data[15:8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] lane_mask(input logic [15:0] d, input logic [1:0] be);
        return {be[1] ? d[15:8] : 8'h00, be[0] ? d[7:0] : 8'h00};
    endfunction

    // Reference model: each accepted transfer fixes the strobe schedule by cycle number.
    bit            model_on = 0;
    int            free_at  = 0;
    int            t_acc    = 0;
    int            kind     = 0;
    logic [AW-1:0] m_addr, last_addr;
    logic [1:0]    m_be;
    logic [DW-1:0] last_rdata;
    bit            m_gnt;

    always @(negedge clock) begin : model
        bit            busy, greq, gnt_eff, rd, wr;
        logic          e_ce, e_oe, e_we, e_rdv;
        logic [1:0]    e_ben, be;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        busy    = cyc < free_at;
        gnt_eff = busy ? m_gnt : sel;
        rd      = gnt_eff ? tr_read : sopc_read;
        wr      = gnt_eff ? tr_write : sopc_write;
        a       = gnt_eff ? tr_address : sopc_address;
        be      = gnt_eff ? tr_byteenable : sopc_byteenable;
        wd      = gnt_eff ? tr_writedata : sopc_writedata;
        greq    = rd | wr;
        if (model_on) begin
            e_ce = 1; e_oe = 1; e_we = 1; e_ben = 2'b11; e_rdv = 0;
            if (kind == 1 && cyc > t_acc && cyc <= t_acc + RD) begin
                e_ce = 0; e_oe = 0; e_ben = ~m_be;
            end
            if (kind == 1 && cyc == t_acc + RD + 1) begin
                e_rdv = 1;
                last_rdata = lane_mask(ref_mem[m_addr[5:0]], m_be);
            end
            if (kind == 2 && cyc > t_acc && cyc <= t_acc + WR + 1) begin
                e_ce = 0; e_ben = ~m_be; e_we = (cyc == t_acc + WR + 1);
            end
            chk("ce_n", 32'(sram_ce_n), 32'(e_ce));
            chk("oe_n", 32'(sram_oe_n), 32'(e_oe));
            chk("we_n", 32'(sram_we_n), 32'(e_we));
            chk("be_n", 32'(sram_be_n), 32'(e_ben));
            chk("address", 32'(sram_address), 32'(last_addr));
            chk("readdataready", 32'(sopc_readdataready), 32'(e_rdv));
            chk("readdata", 32'(sopc_readdata), 32'(last_rdata));
            chk("waitrequest", 32'(sopc_waitrequest), 32'(reset || (busy && greq)));
        end
        if (reset) begin
            model_on   = 1;
            kind       = 0;
            free_at    = cyc + 1;
            last_addr  = '0;
            last_rdata = '0;
            m_gnt      = 0;
        end else if (model_on) begin
            m_gnt = gnt_eff;
            if (!busy && greq) begin
                t_acc = cyc; m_addr = a; m_be = be; last_addr = a;
                if (rd) begin
                    kind = 1; free_at = cyc + RD + 1;
                end else begin
                    kind = 2; free_at = cyc + WR + 2;
                    if (be[0]) ref_mem[a[5:0]][7:0]  = wd[7:0];
                    if (be[1]) ref_mem[a[5:0]][15:8] = wd[15:8];
                end
            end
        end
    end

    int            oe_low = 0;
    int            we_low = 0;
    int            rdv_cyc[$];
    logic [DW-1:0] rdv_dat[$];

    always @(negedge clock) begin
        if (!sram_oe_n) oe_low++;
        if (!sram_we_n) we_low++;
        if (sopc_readdataready) begin
            rdv_cyc.push_back(cyc);
            rdv_dat.push_back(sopc_readdata);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_accept(input string name, output int c);
        c = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (!sopc_waitrequest) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk({name, "_accept_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_rdv(input string name, input int k);
        int n;
        n = 0;
        while (rdv_cyc.size() < k && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (rdv_cyc.size() < k) chk({name, "_rdv_timeout"}, 32'(rdv_cyc.size()), 32'(k));
    endtask

    task automatic sopc_req(input bit rd, input bit wr, input logic [AW-1:0] a,
                            input logic [1:0] be, input logic [DW-1:0] wd);
        sopc_read = rd; sopc_write = wr; sopc_address = a; sopc_byteenable = be; sopc_writedata = wd;
    endtask

    initial begin
        int acc1, acc2;
        for (int i = 0; i < 64; i++) dev_mem[i] = 16'(i * 257);
        dev_mem[0] = 16'h1111; dev_mem[1] = 16'h2222; dev_mem[16] = 16'hBEEF;
        dev_mem[32] = 16'hA5C3; dev_mem[48] = 16'hC0DE;
        for (int i = 0; i < 64; i++) ref_mem[i] = dev_mem[i];

        reset = 1; sel = 0;
        sopc_req(0, 0, '0, 2'b00, '0);
        tr_read = 0; tr_write = 0; tr_address = '0; tr_byteenable = 2'b00; tr_writedata = '0;
        repeat (3) step();
        @(negedge clock);
        chk("reset_waitrequest", 32'(sopc_waitrequest), 32'd1);
        step();
        reset = 0;
        @(negedge clock);
        chk("reset_address", 32'(sram_address), 32'h0);
        chk("reset_readdata", 32'(sopc_readdata), 32'h0);
        chk("reset_be_n", 32'(sram_be_n), 32'h3);

        // Single read
        step();
        oe_low = 0; rdv_cyc.delete(); rdv_dat.delete();
        sopc_req(1, 0, 20'h00010, 2'b11, '0);
        wait_accept("rd1", acc1);
        step();
        sopc_req(0, 0, '0, 2'b00, '0);
        wait_rdv("rd1", 1);
        if (rdv_cyc.size() >= 1) begin
            chk("rd1_latency", 32'(rdv_cyc[0] - acc1), 32'd3);
            chk("rd1_data", 32'(rdv_dat[0]), 32'h0000BEEF);
        end
        chk("rd1_oe_cycles", 32'(oe_low), 32'd2);

        // Low-byte write, then read back
        step();
        we_low = 0;
        sopc_req(0, 1, 20'h00020, 2'b01, 16'h1234);
        wait_accept("wr1", acc1);
        step();
        sopc_req(0, 0, '0, 2'b00, '0);
        repeat (4) step();
        chk("wr1_we_cycles", 32'(we_low), 32'd2);
        rdv_cyc.delete(); rdv_dat.delete();
        sopc_req(1, 0, 20'h00020, 2'b11, '0);
        wait_accept("rb1", acc1);
        step();
        sopc_req(0, 0, '0, 2'b00, '0);
        wait_rdv("rb1", 1);
        if (rdv_dat.size() >= 1) chk("rb1_data", 32'(rdv_dat[0]), 32'h0000A534);

        // tr port granted while sopc holds a write
        step();
        sel = 1; rdv_cyc.delete(); rdv_dat.delete();
        sopc_req(0, 1, 20'h00005, 2'b11, 16'hFFFF);
        tr_read = 1; tr_address = 20'h00030; tr_byteenable = 2'b11;
        wait_accept("tr1", acc1);
        @(negedge clock);
        chk("tr1_busy_waitrequest", 32'(sopc_waitrequest), 32'd1);
        step();
        tr_read = 0;
        wait_rdv("tr1", 1);
        if (rdv_dat.size() >= 1) chk("tr1_data", 32'(rdv_dat[0]), 32'h0000C0DE);
        sopc_req(0, 0, '0, 2'b00, '0);
        step();
        sel = 0;
        chk("tr1_sopc_write_ignored", 32'(dev_mem[5]), 32'h00000505);

        // Back-to-back reads
        step();
        rdv_cyc.delete(); rdv_dat.delete();
        sopc_req(1, 0, 20'h00000, 2'b11, '0);
        wait_accept("b2b_a", acc1);
        step();
        sopc_address = 20'h00001;
        wait_accept("b2b_b", acc2);
        step();
        sopc_req(0, 0, '0, 2'b00, '0);
        wait_rdv("b2b", 2);
        if (rdv_cyc.size() >= 2) begin
            chk("b2b_second_accept", 32'(acc2), 32'(rdv_cyc[0]));
            chk("b2b_spacing", 32'(rdv_cyc[1] - rdv_cyc[0]), 32'd3);
            chk("b2b_data0", 32'(rdv_dat[0]), 32'h00001111);
            chk("b2b_data1", 32'(rdv_dat[1]), 32'h00002222);
        end

        // Reset during the first write cycle
        step();
        rdv_cyc.delete(); rdv_dat.delete();
        sopc_req(0, 1, 20'h00008, 2'b11, 16'h5555);
        wait_accept("wrst", acc1);
        step();
        reset = 1;
        sopc_req(0, 0, '0, 2'b00, '0);
        @(negedge clock);
        chk("wrst_we_low_first", 32'(sram_we_n), 32'd0);
        @(negedge clock);
        chk("wrst_we_released", 32'(sram_we_n), 32'd1);
        chk("wrst_ce_released", 32'(sram_ce_n), 32'd1);
        step();
        reset = 0;
        repeat (3) step();
        chk("wrst_no_rdv", 32'(rdv_cyc.size()), 32'd0);

        // Read and write together: read wins
        we_low = 0; rdv_cyc.delete(); rdv_dat.delete();
        sopc_req(1, 1, 20'h00010, 2'b11, 16'h0000);
        wait_accept("rw", acc1);
        step();
        sopc_req(0, 0, '0, 2'b00, '0);
        wait_rdv("rw", 1);
        if (rdv_dat.size() >= 1) chk("rw_data", 32'(rdv_dat[0]), 32'h0000BEEF);
        repeat (3) step();
        chk("rw_no_write_strobe", 32'(we_low), 32'd0);
        chk("rw_mem_unchanged", 32'(dev_mem[16]), 32'h0000BEEF);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
